// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the limb pipeline fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // ARM-style "always" condition code and the NOP body (MOV-hint encoding).
  localparam logic [3:0]         COND_AL   = 4'hE;
  localparam logic [27:0]        NOP_BODY  = 28'h320_F000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = {COND_AL, NOP_BODY};

  // One prefetch buffer entry: the word address and the word fetched from it.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_fetch_buffer.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs between the
// instruction-memory handshake and the decode-facing output register.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  pop_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Qualify requests; flush discards everything including a same-cycle push.
  always_comb begin
    do_push = push && !full && !flush;
    do_pop  = pop && !empty && !flush;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are only ever read while count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one-at-a-time word requests to instruction memory,
// buffers returned words and hands one instruction per cycle to decode.
// Branch redirects flush the buffer and drop a request already in flight.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned DEPTH        = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_pc_next;
  logic [31:0]   branch_pc;
  logic          discard;
  logic          ack_fire;
  logic          held;
  logic          push;
  logic          pop;
  logic          req_next;
  logic [CW-1:0] count_next;
  fetch_entry_t  push_entry;
  fetch_entry_t  pop_entry;
  logic [CW-1:0] buf_count;
  logic          buf_empty;
  logic          buf_full;

  // Handshake decode and look-ahead occupancy used to decide the next request.
  always_comb begin
    ack_fire         = imem_req_o && imem_ack_i;
    held             = imem_req_o && !imem_ack_i;
    push             = ack_fire && !discard && !branch_i;
    pop              = !branch_i && !stall_i && !buf_empty;
    count_next       = branch_i ? '0 : buf_count + CW'(push) - CW'(pop);
    req_next         = (count_next < CW'(DEPTH));
    fetch_pc_next    = (ack_fire && !discard) ? fetch_pc + 32'd4 : fetch_pc;
    branch_pc        = word_align(branch_target_i);
    push_entry       = '0;
    push_entry.pc    = imem_addr_o;
    push_entry.instr = imem_data_i;
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (branch_i),
    .pop_data  (pop_entry),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // Request side. fetch_pc is the next address to fetch; imem_addr_o only
  // diverges from it while a pre-branch request is still waiting to be
  // acked and discarded. The request is re-evaluated every cycle it is not
  // held, so zero-wait memory sustains one fetch per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_VECTOR;
      fetch_pc    <= RESET_VECTOR;
      discard     <= 1'b0;
    end else if (branch_i) begin
      fetch_pc <= branch_pc;
      if (held) begin
        discard <= 1'b1;
      end else begin
        discard     <= 1'b0;
        imem_req_o  <= 1'b1;
        imem_addr_o <= branch_pc;
      end
    end else if (!held) begin
      fetch_pc    <= fetch_pc_next;
      imem_addr_o <= fetch_pc_next;
      imem_req_o  <= req_next;
      discard     <= 1'b0;
    end
  end

  // Decode-facing output register: flush beats stall, stall holds, otherwise pop or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_o       <= NOP_INSTR;
      instr_valid_o <= 1'b0;
      pc_o          <= RESET_VECTOR;
    end else if (branch_i) begin
      instr_o       <= NOP_INSTR;
      instr_valid_o <= 1'b0;
      pc_o          <= branch_pc;
    end else if (!stall_i) begin
      if (!buf_empty) begin
        instr_o       <= pop_entry.instr;
        instr_valid_o <= 1'b1;
        pc_o          <= pop_entry.pc;
      end else begin
        instr_o       <= NOP_INSTR;
        instr_valid_o <= 1'b0;
      end
    end
  end

  // The request throttle must keep the buffer from ever overflowing.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && buf_full));

  // A request waiting for ack keeps its request and address.
  a_req_held : assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_o && !imem_ack_i) |=> (imem_req_o && $stable(imem_addr_o)));

endmodule
